// File: rtl/pattern_seq_ctrl.sv
// Purpose: frame/line timing generator plus a programmable table of pattern configs
//          (Mode, constVal, X, Y). It presents one entry per N frames to the pattern generator.
// Latency: all outputs are registered. A config is latched on the same edge that raises f_sync.
// Backpressure: none. enable is a level; dropping it lets the current frame finish before IDLE.
// Optional feature: define PATSEQ_FRAME_DONE_EN to add the frame_done and seq_wrap pulse outputs.
module pattern_seq_ctrl #(
    parameter int H_ACTIVE = 64,
    parameter int H_BLANK  = 8,
    parameter int V_LINES  = 16,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [18:0]       cfg_wdata,
    input  logic [ADDR_W:0]   num_entries,
    input  logic [7:0]        frames_per_pat,
    output logic              f_sync,
    output logic              sync,
    output logic              line_active,
    output logic [2:0]        Mode,
    output logic [11:0]       constVal,
    output logic [1:0]        X,
    output logic [1:0]        Y,
    output logic [ADDR_W-1:0] pat_idx,
    output logic              busy
`ifdef PATSEQ_FRAME_DONE_EN
    ,
    output logic              frame_done,
    output logic              seq_wrap
`endif
);

    localparam int HMAX = (H_ACTIVE > H_BLANK) ? H_ACTIVE : H_BLANK;
    localparam int CC_W = (HMAX > 1) ? $clog2(HMAX) : 1;
    localparam int LC_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;

    localparam logic [CC_W-1:0]   ACT_LAST = CC_W'(H_ACTIVE - 1);
    localparam logic [CC_W-1:0]   BLK_LAST = CC_W'(H_BLANK - 1);
    localparam logic [LC_W-1:0]   LINE_LAST = LC_W'(V_LINES - 1);
    localparam logic [ADDR_W:0]   NUM_MAX  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ACTIVE,
        ST_HBLANK
    } state_t;

    state_t            state_q, state_d;
    logic [CC_W-1:0]   cyc_q, cyc_d;
    logic [LC_W-1:0]   line_q, line_d;
    logic [7:0]        frame_q, frame_d;
    logic [ADDR_W-1:0] pat_idx_q, pat_idx_d;
    logic [18:0]       table_q [DEPTH];
    logic [18:0]       table_d [DEPTH];
    logic [18:0]       cfg_q, cfg_d;
    logic              f_sync_q, f_sync_d;
    logic              sync_q, sync_d;
    logic              line_active_q, line_active_d;
    logic              busy_q, busy_d;

    logic [ADDR_W:0]   eff_num;
    logic [ADDR_W:0]   num_last;
    logic [7:0]        eff_fpp;
    logic [7:0]        fpp_last;
    logic              idx_at_last;

    // Effective sequence length and frame repeat count; zero means one, length clamps to DEPTH.
    always_comb begin
        eff_num = num_entries;
        if (num_entries == '0) begin
            eff_num = (ADDR_W + 1)'(1);
        end else if (num_entries > NUM_MAX) begin
            eff_num = NUM_MAX;
        end
        eff_fpp     = (frames_per_pat == 8'd0) ? 8'd1 : frames_per_pat;
        num_last    = eff_num - 1'b1;
        fpp_last    = eff_fpp - 8'd1;
        idx_at_last = ({1'b0, pat_idx_q} >= num_last);
    end

    // Table writes. Because the latch reads table_q, it sees pre-write contents on a colliding edge.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            table_d[i] = table_q[i];
        end
        if (cfg_we) begin
            table_d[cfg_addr] = cfg_wdata;
        end
    end

    // Sequencer next state. Strobes and the config latch are derived from the next state so they
    // line up with the state register.
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        line_d    = line_q;
        frame_d   = frame_q;
        pat_idx_d = pat_idx_q;
        case (state_q)
            ST_IDLE: begin
                cyc_d     = '0;
                line_d    = '0;
                frame_d   = 8'd0;
                pat_idx_d = '0;
                if (enable) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                cyc_d   = '0;
                state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (cyc_q == ACT_LAST) begin
                    cyc_d   = '0;
                    state_d = ST_HBLANK;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            ST_HBLANK: begin
                if (cyc_q != BLK_LAST) begin
                    cyc_d = cyc_q + 1'b1;
                end else if (line_q != LINE_LAST) begin
                    cyc_d   = '0;
                    line_d  = line_q + 1'b1;
                    state_d = ST_SYNC;
                end else begin
                    // Frame end: step the frame counter and, every eff_fpp frames, the table index.
                    cyc_d  = '0;
                    line_d = '0;
                    if (frame_q >= fpp_last) begin
                        frame_d   = 8'd0;
                        pat_idx_d = idx_at_last ? '0 : pat_idx_q + 1'b1;
                    end else begin
                        frame_d = frame_q + 8'd1;
                        if ({1'b0, pat_idx_q} >= eff_num) begin
                            pat_idx_d = '0;
                        end
                    end
                    if (enable) begin
                        state_d = ST_SYNC;
                    end else begin
                        state_d   = ST_IDLE;
                        frame_d   = 8'd0;
                        pat_idx_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        sync_d        = (state_d == ST_SYNC);
        f_sync_d      = sync_d && (line_d == '0);
        line_active_d = (state_d == ST_ACTIVE);
        busy_d        = (state_d != ST_IDLE);
        cfg_d         = f_sync_d ? table_q[pat_idx_d] : cfg_q;
    end

`ifdef PATSEQ_FRAME_DONE_EN
    logic frame_done_q, frame_done_d;
    logic seq_wrap_q, seq_wrap_d;

    // End-of-frame pulses, raised on the edge entering the last HBLANK cycle of the last line.
    always_comb begin
        frame_done_d = (state_d == ST_HBLANK) && (cyc_d == BLK_LAST) && (line_d == LINE_LAST);
        seq_wrap_d   = frame_done_d && (frame_q >= fpp_last) && idx_at_last;
    end

    // Pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done_q <= 1'b0;
            seq_wrap_q   <= 1'b0;
        end else begin
            frame_done_q <= frame_done_d;
            seq_wrap_q   <= seq_wrap_d;
        end
    end

    assign frame_done = frame_done_q;
    assign seq_wrap   = seq_wrap_q;
`endif

    // State, counters, table and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cyc_q         <= '0;
            line_q        <= '0;
            frame_q       <= 8'd0;
            pat_idx_q     <= '0;
            cfg_q         <= '0;
            f_sync_q      <= 1'b0;
            sync_q        <= 1'b0;
            line_active_q <= 1'b0;
            busy_q        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            line_q        <= line_d;
            frame_q       <= frame_d;
            pat_idx_q     <= pat_idx_d;
            cfg_q         <= cfg_d;
            f_sync_q      <= f_sync_d;
            sync_q        <= sync_d;
            line_active_q <= line_active_d;
            busy_q        <= busy_d;
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

    assign f_sync      = f_sync_q;
    assign sync        = sync_q;
    assign line_active = line_active_q;
    assign busy        = busy_q;
    assign pat_idx     = pat_idx_q;
    assign Mode        = cfg_q[18:16];
    assign Y           = cfg_q[15:14];
    assign X           = cfg_q[13:12];
    assign constVal    = cfg_q[11:0];

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Bench for pattern_seq_ctrl with small timing parameters (4 active, 2 blank, 3 lines).
// Expected values come from arithmetic on the cycle count since the run started.
// Output vector layout: {f_sync, sync, line_active, busy, pat_idx, Mode, Y, X, constVal}.
module tb_pattern_seq_ctrl;

    localparam int HA = 4;
    localparam int HB = 2;
    localparam int VL = 3;
    localparam int LP = 1 + HA + HB;
    localparam int FP = VL * LP;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [18:0] cfg_wdata = '0;
    logic [3:0]  num_entries = '0;
    logic [7:0]  frames_per_pat = '0;
    logic        f_sync, sync, line_active, busy;
    logic [2:0]  Mode;
    logic [11:0] constVal;
    logic [1:0]  X, Y;
    logic [2:0]  pat_idx;
`ifdef PATSEQ_FRAME_DONE_EN
    logic        frame_done, seq_wrap;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [18:0] tbl [8];
    int          m_num;
    int          m_fpp;

    pattern_seq_ctrl #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_LINES(VL), .DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .num_entries(num_entries), .frames_per_pat(frames_per_pat),
        .f_sync(f_sync), .sync(sync), .line_active(line_active),
        .Mode(Mode), .constVal(constVal), .X(X), .Y(Y),
        .pat_idx(pat_idx), .busy(busy)
`ifdef PATSEQ_FRAME_DONE_EN
        , .frame_done(frame_done), .seq_wrap(seq_wrap)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [25:0] observed();
        return {f_sync, sync, line_active, busy, pat_idx, Mode, Y, X, constVal};
    endfunction

    function automatic int eff_num();
        return (m_num == 0) ? 1 : ((m_num > 8) ? 8 : m_num);
    endfunction

    function automatic int eff_fpp();
        return (m_fpp == 0) ? 1 : m_fpp;
    endfunction

    function automatic int frame_idx(int f);
        return (f / eff_fpp()) % eff_num();
    endfunction

    // Expected outputs k cycles after the first SYNC cycle of a run.
    function automatic logic [25:0] model_run(int k);
        int          pos, col, idx;
        logic [2:0]  i3;
        logic [18:0] e;
        pos = k % FP;
        col = pos % LP;
        idx = frame_idx(k / FP);
        i3  = idx[2:0];
        e   = tbl[idx];
        return {pos == 0, col == 0, (col >= 1 && col <= HA), 1'b1, i3, e};
    endfunction

    task automatic apply_reset();
        enable = 1'b0;
        cfg_we = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tbl[i] = '0;
    endtask

    task automatic write_entry(input int a, input logic [18:0] d);
        logic [2:0] a3;
        a3 = a[2:0];
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = a3;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
        tbl[a] = d;
    endtask

    task automatic set_seq(input int n, input int fpp);
        logic [3:0] n4;
        logic [7:0] f8;
        n4 = n[3:0];
        f8 = fpp[7:0];
        m_num = n;
        m_fpp = fpp;
        num_entries    = n4;
        frames_per_pat = f8;
    endtask

    // Raise enable; the next negedge is cycle k=0 of the run.
    task automatic start_run();
        @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic test_reset();
        logic [25:0] obs;
        rst = 1'b1;
        #1;
        obs = observed();
        n_checks++;
        if (obs !== 26'd0) $display("FAIL reset_outputs: got %h want %h", obs, 26'd0);
        else n_pass++;
`ifdef PATSEQ_FRAME_DONE_EN
        n_checks++;
        if ({frame_done, seq_wrap} !== 2'b00) $display("FAIL reset_pulses: got %b want 00", {frame_done, seq_wrap});
        else n_pass++;
`endif
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = observed();
            n_checks++;
            if (obs !== 26'd0) $display("FAIL idle_after_reset: got %h want %h", obs, 26'd0);
            else n_pass++;
        end
    endtask

    // Two fixed entries, two frames each; five frames shows entry 0 returning.
    task automatic test_basic_seq();
        logic [25:0] obs, exp;
        apply_reset();
        write_entry(0, {3'd1, 2'd1, 2'd2, 12'h123});
        write_entry(1, {3'd3, 2'd0, 2'd1, 12'hABC});
        set_seq(2, 2);
        start_run();
        for (int k = 0; k < 5 * FP; k++) begin
            @(negedge clk);
            obs = observed();
            exp = model_run(k);
            n_checks++;
            if (obs !== exp) $display("FAIL basic_seq k=%0d: got %h want %h", k, obs, exp);
            else n_pass++;
        end
    endtask

    task automatic test_random_seq();
        logic [25:0] obs, exp;
        for (int it = 0; it < 3; it++) begin
            apply_reset();
            for (int i = 0; i < 8; i++) write_entry(i, 19'($urandom));
            set_seq($urandom_range(0, 15), $urandom_range(0, 3));
            start_run();
            for (int k = 0; k < 8 * FP; k++) begin
                @(negedge clk);
                obs = observed();
                exp = model_run(k);
                n_checks++;
                if (obs !== exp) $display("FAIL random_seq it=%0d n=%0d fpp=%0d k=%0d: got %h want %h",
                                          it, m_num, m_fpp, k, obs, exp);
                else n_pass++;
            end
        end
    endtask

    // Drop enable during line 1; the frame finishes, then IDLE; re-enable restarts at entry 0.
    task automatic test_enable_drop();
        logic [25:0] obs, exp, last;
        int          fd, stop;
        apply_reset();
        for (int i = 0; i < 4; i++) write_entry(i, 19'($urandom));
        set_seq(3, 1);
        fd   = $urandom_range(0, 1);
        stop = FP * fd + LP + $urandom_range(0, LP - 1);
        start_run();
        for (int k = 0; k < FP * (fd + 1); k++) begin
            @(negedge clk);
            obs = observed();
            exp = model_run(k);
            n_checks++;
            if (obs !== exp) $display("FAIL enable_drop k=%0d: got %h want %h", k, obs, exp);
            else n_pass++;
            if (k == stop) enable = 1'b0;
        end
        last = model_run(FP * (fd + 1) - 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            obs = observed();
            exp = {7'd0, last[18:0]};
            n_checks++;
            if (obs !== exp) $display("FAIL enable_drop_idle c=%0d: got %h want %h", i, obs, exp);
            else n_pass++;
        end
        start_run();
        for (int k = 0; k < 2 * FP; k++) begin
            @(negedge clk);
            obs = observed();
            exp = model_run(k);
            n_checks++;
            if (obs !== exp) $display("FAIL enable_restart k=%0d: got %h want %h", k, obs, exp);
            else n_pass++;
        end
    endtask

    // Reset in ACTIVE clears outputs at once and empties the table.
    task automatic test_async_reset();
        logic [25:0] obs, exp;
        apply_reset();
        write_entry(0, 19'h7FFFF);
        write_entry(1, 19'h5A5A5);
        set_seq(2, 1);
        start_run();
        for (int k = 0; k < FP + 3; k++) begin
            @(negedge clk);
            obs = observed();
            exp = model_run(k);
            n_checks++;
            if (obs !== exp) $display("FAIL pre_reset k=%0d: got %h want %h", k, obs, exp);
            else n_pass++;
        end
        rst    = 1'b1;
        enable = 1'b0;
        #1;
        obs = observed();
        n_checks++;
        if (obs !== 26'd0) $display("FAIL async_reset: got %h want %h", obs, 26'd0);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tbl[i] = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            obs = observed();
            n_checks++;
            if (obs !== 26'd0) $display("FAIL post_reset_idle c=%0d: got %h want %h", i, obs, 26'd0);
            else n_pass++;
        end
        start_run();
        for (int k = 0; k < 2 * FP; k++) begin
            @(negedge clk);
            obs = observed();
            exp = model_run(k);
            n_checks++;
            if (obs !== exp) $display("FAIL cleared_table k=%0d: got %h want %h", k, obs, exp);
            else n_pass++;
        end
    endtask

    // Zero counts act as one; a write to entry 0 on a latch edge shows up one frame later.
    task automatic test_zero_and_collision();
        logic [25:0] obs, exp;
        logic [18:0] a, b;
        apply_reset();
        a = 19'($urandom);
        b = ~a;
        write_entry(0, a);
        write_entry(1, 19'($urandom));
        set_seq(0, 0);
        start_run();
        for (int k = 0; k < 3 * FP; k++) begin
            if (k == 2 * FP) tbl[0] = b;
            @(negedge clk);
            obs = observed();
            exp = model_run(k);
            n_checks++;
            if (obs !== exp) $display("FAIL zero_collision k=%0d: got %h want %h", k, obs, exp);
            else n_pass++;
            if (k == FP - 1) begin
                cfg_we    = 1'b1;
                cfg_addr  = 3'd0;
                cfg_wdata = b;
            end else if (k == FP) begin
                cfg_we = 1'b0;
            end
        end
    endtask

`ifdef PATSEQ_FRAME_DONE_EN
    task automatic test_frame_done();
        logic [1:0] obs, exp;
        int         f;
        logic       fd;
        apply_reset();
        write_entry(0, {3'd1, 2'd1, 2'd2, 12'h123});
        write_entry(1, {3'd3, 2'd0, 2'd1, 12'hABC});
        set_seq(2, 2);
        start_run();
        for (int k = 0; k < 8 * FP; k++) begin
            @(negedge clk);
            f   = k / FP;
            fd  = (k % FP == FP - 1);
            exp = {fd, fd && (f % eff_fpp() == eff_fpp() - 1) && (frame_idx(f) == eff_num() - 1)};
            obs = {frame_done, seq_wrap};
            n_checks++;
            if (obs !== exp) $display("FAIL frame_done k=%0d: got %b want %b", k, obs, exp);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        m_num = 1;
        m_fpp = 1;
        for (int i = 0; i < 8; i++) tbl[i] = '0;
        test_reset();
        test_basic_seq();
        test_random_seq();
        test_enable_drop();
        test_async_reset();
        test_zero_and_collision();
`ifdef PATSEQ_FRAME_DONE_EN
        test_frame_done();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
